// File: rtl/palette_pkg.sv
// Shared definitions for the writable colour palette: host register map and
// the upload / read-back state encodings.
package palette_pkg;

    localparam logic [1:0] PAL_WIDX  = 2'd0;
    localparam logic [1:0] PAL_WDATA = 2'd1;
    localparam logic [1:0] PAL_RIDX  = 2'd2;
    localparam logic [1:0] PAL_RDATA = 2'd3;

    typedef enum logic [1:0] {
        W_R = 2'd0,
        W_G = 2'd1,
        W_B = 2'd2
    } wstate_t;

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_FETCH1 = 3'd1,
        R_FETCH2 = 3'd2,
        R_R      = 3'd3,
        R_G      = 3'd4,
        R_B      = 3'd5
    } rstate_t;

endpackage

// File: rtl/palette_dpram.sv
// Palette storage: registered read port A for pixels, read/write port B for
// the host, single clock; contents start undefined.
module palette_dpram
    import palette_pkg::*;
#(
    parameter int    ADDR_BITS = 9,
    parameter int    DATA_BITS = 24,
    parameter string FILENAME  = ""
) (
    input  logic                 clk_pix,
    input  logic [ADDR_BITS-1:0] a_addr,
    output logic [DATA_BITS-1:0] a_rdata,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic                 b_we,
    input  logic [DATA_BITS-1:0] b_wdata,
    input  logic                 b_re,
    output logic [DATA_BITS-1:0] b_rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem_r [DEPTH];

    // Port A pixel read (read-first against a same-cycle port B write)
    always_ff @(posedge clk_pix) begin
        a_rdata <= mem_r[a_addr];
    end

    // Port B host write, or read-back fetch when not writing
    always_ff @(posedge clk_pix) begin
        if (b_we) begin
            mem_r[b_addr] <= b_wdata;
        end else if (b_re) begin
            b_rdata <= mem_r[b_addr];
        end
    end

endmodule

// File: rtl/palette_ram.sv
// Writable colour palette: 2-clock pixel lookup with blanking, DAC-style host
// upload (index then R,G,B with auto-increment); read-back under PALETTE_READBACK_EN.
module palette_ram
    import palette_pkg::*;
#(
    parameter int    INDEX_BITS = 9,
    parameter int    CHAN_BITS  = 8,
    parameter string FILENAME   = ""
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] colour_pix,
    input  logic                  de_pix,
    output logic [CHAN_BITS-1:0]  r,
    output logic [CHAN_BITS-1:0]  g,
    output logic [CHAN_BITS-1:0]  b,
    output logic                  de_out,
    input  logic [1:0]            reg_addr,
    input  logic                  reg_we,
    input  logic                  reg_re,
    input  logic [15:0]           reg_wdata,
    output logic [15:0]           reg_rdata,
    output logic                  reg_busy
);
    localparam int                    WORD_BITS = 3 * CHAN_BITS;
    localparam logic [INDEX_BITS-1:0] IDX_ZERO  = {INDEX_BITS{1'b0}};
    localparam logic [INDEX_BITS-1:0] IDX_ONE   = {{(INDEX_BITS-1){1'b0}}, 1'b1};
    localparam logic [CHAN_BITS-1:0]  CHAN_ZERO = {CHAN_BITS{1'b0}};

    logic [WORD_BITS-1:0]  pix_word_s;
    logic                  de1_r;
    logic [INDEX_BITS-1:0] b_addr_s;
    logic                  b_re_s;
    logic [WORD_BITS-1:0]  b_rdata_s;

    wstate_t               wstate_r, wstate_s;
    logic [INDEX_BITS-1:0] widx_r;
    logic [CHAN_BITS-1:0]  r_lat_r, g_lat_r;
    logic                  widx_load_s, lat_r_s, lat_g_s, commit_s;
    logic                  unused_s;

    palette_dpram #(
        .ADDR_BITS (INDEX_BITS),
        .DATA_BITS (WORD_BITS),
        .FILENAME  (FILENAME)
    ) u_dpram (
        .clk_pix (clk_pix),
        .a_addr  (colour_pix),
        .a_rdata (pix_word_s),
        .b_addr  (b_addr_s),
        .b_we    (commit_s),
        .b_wdata ({r_lat_r, g_lat_r, reg_wdata[CHAN_BITS-1:0]}),
        .b_re    (b_re_s),
        .b_rdata (b_rdata_s)
    );

    // Pixel pipeline: stage 1 is the RAM register plus DE, stage 2 blanks and aligns
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            de1_r  <= 1'b0;
            r      <= CHAN_ZERO;
            g      <= CHAN_ZERO;
            b      <= CHAN_ZERO;
            de_out <= 1'b0;
        end else begin
            de1_r  <= de_pix;
            r      <= de1_r ? pix_word_s[WORD_BITS-1 -: CHAN_BITS]   : CHAN_ZERO;
            g      <= de1_r ? pix_word_s[2*CHAN_BITS-1 -: CHAN_BITS] : CHAN_ZERO;
            b      <= de1_r ? pix_word_s[CHAN_BITS-1:0]              : CHAN_ZERO;
            de_out <= de1_r;
        end
    end

    // Upload FSM next state; an index write always restarts at R
    always_comb begin
        wstate_s    = wstate_r;
        widx_load_s = 1'b0;
        lat_r_s     = 1'b0;
        lat_g_s     = 1'b0;
        commit_s    = 1'b0;
        if (reg_we && (reg_addr == PAL_WIDX)) begin
            widx_load_s = 1'b1;
            wstate_s    = W_R;
        end else if (reg_we && (reg_addr == PAL_WDATA)) begin
            case (wstate_r)
                W_R: begin
                    lat_r_s  = 1'b1;
                    wstate_s = W_G;
                end
                W_G: begin
                    lat_g_s  = 1'b1;
                    wstate_s = W_B;
                end
                W_B: begin
                    commit_s = 1'b1;
                    wstate_s = W_R;
                end
                default: wstate_s = W_R;
            endcase
        end else begin
            wstate_s = wstate_r;
        end
    end

    // Upload FSM state, write index and latched components
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            wstate_r <= W_R;
            widx_r   <= IDX_ZERO;
            r_lat_r  <= CHAN_ZERO;
            g_lat_r  <= CHAN_ZERO;
        end else begin
            wstate_r <= wstate_s;
            if (widx_load_s) begin
                widx_r <= reg_wdata[INDEX_BITS-1:0];
            end else if (commit_s) begin
                widx_r <= widx_r + IDX_ONE;
            end
            if (lat_r_s) begin
                r_lat_r <= reg_wdata[CHAN_BITS-1:0];
            end
            if (lat_g_s) begin
                g_lat_r <= reg_wdata[CHAN_BITS-1:0];
            end
        end
    end

`ifdef PALETTE_READBACK_EN
    rstate_t               rstate_r, rstate_s;
    logic [INDEX_BITS-1:0] ridx_r;
    logic [WORD_BITS-1:0]  hold_r, hold_next_s;
    logic                  ridx_load_s, ridx_inc_s, hold_load_s, rd_s;
    logic [15:0]           rdata_s;

    // Port B is shared; an upload commit takes it ahead of a fetch
    assign b_addr_s    = commit_s ? widx_r : ridx_r;
    assign rd_s        = reg_re && !reg_we && (reg_addr == PAL_RDATA);
    assign hold_next_s = hold_load_s ? b_rdata_s : hold_r;
    assign unused_s    = ^reg_wdata;

    // Read-back FSM next state; a read-index write restarts from any state
    always_comb begin
        rstate_s    = rstate_r;
        ridx_load_s = 1'b0;
        ridx_inc_s  = 1'b0;
        hold_load_s = 1'b0;
        b_re_s      = 1'b0;
        if (reg_we && (reg_addr == PAL_RIDX)) begin
            ridx_load_s = 1'b1;
            rstate_s    = R_FETCH1;
        end else begin
            case (rstate_r)
                R_IDLE:   rstate_s = R_IDLE;
                R_FETCH1: begin
                    if (!commit_s) begin
                        b_re_s   = 1'b1;
                        rstate_s = R_FETCH2;
                    end else begin
                        rstate_s = R_FETCH1;
                    end
                end
                R_FETCH2: begin
                    hold_load_s = 1'b1;
                    rstate_s    = R_R;
                end
                R_R: rstate_s = rd_s ? R_G : R_R;
                R_G: rstate_s = rd_s ? R_B : R_G;
                R_B: begin
                    if (rd_s) begin
                        ridx_inc_s = 1'b1;
                        rstate_s   = R_FETCH1;
                    end else begin
                        rstate_s = R_B;
                    end
                end
                default: rstate_s = R_IDLE;
            endcase
        end
    end

    // Component shown next cycle, chosen by the state being entered
    always_comb begin
        rdata_s = 16'd0;
        case (rstate_s)
            R_R:     rdata_s = 16'(hold_next_s[WORD_BITS-1 -: CHAN_BITS]);
            R_G:     rdata_s = 16'(hold_next_s[2*CHAN_BITS-1 -: CHAN_BITS]);
            R_B:     rdata_s = 16'(hold_next_s[CHAN_BITS-1:0]);
            default: rdata_s = 16'd0;
        endcase
    end

    // Read-back state, index, holding register and registered host outputs
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            rstate_r  <= R_IDLE;
            ridx_r    <= IDX_ZERO;
            hold_r    <= {WORD_BITS{1'b0}};
            reg_rdata <= 16'd0;
            reg_busy  <= 1'b0;
        end else begin
            rstate_r  <= rstate_s;
            hold_r    <= hold_next_s;
            reg_rdata <= rdata_s;
            reg_busy  <= (rstate_s == R_FETCH1) || (rstate_s == R_FETCH2);
            if (ridx_load_s) begin
                ridx_r <= reg_wdata[INDEX_BITS-1:0];
            end else if (ridx_inc_s) begin
                ridx_r <= ridx_r + IDX_ONE;
            end
        end
    end
`else
    assign b_addr_s  = widx_r;
    assign b_re_s    = 1'b0;
    assign reg_rdata = 16'd0;
    assign reg_busy  = 1'b0;
    assign unused_s  = ^{reg_wdata, reg_re, b_rdata_s};
`endif

endmodule
